// File: rtl/core_inst_gen.sv
// core_inst_gen: per-tile instruction sequencer in front of `core`.
// Sequence: IDLE -> WRD -> WLOAD -> XRD -> EXEC -> DRAIN -> [RDBK] -> DONE.
// Optional feature macro: CORE_INST_GEN_PMEM_READBACK_EN adds the RDBK state,
// which reads the freshly written psums back out of pmem.
// inst is registered; each cycle's word is built from the next-state values.
module core_inst_gen #(
   parameter int row    = 8,
   parameter int col    = 8,
   parameter int len_bw = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [10:0]       w_base,
   input  logic [10:0]       x_base,
   input  logic [10:0]       p_base,
   input  logic [len_bw-1:0] len,
   input  logic              acc_i,
   input  logic              ofifo_valid,
   output logic [33:0]       inst,
   output logic              busy,
   output logic              done
);

   localparam logic [33:0] NOP = 34'h1_800C_0000;

   localparam int unsigned B_ACC     = 33;
   localparam int unsigned B_CEN_P   = 32;
   localparam int unsigned B_WEN_P   = 31;
   localparam int unsigned B_CEN_X   = 19;
   localparam int unsigned B_OFIFO   = 6;
   localparam int unsigned B_L0_RD   = 3;
   localparam int unsigned B_L0_WR   = 2;
   localparam int unsigned B_EXECUTE = 1;
   localparam int unsigned B_LOAD    = 0;

   localparam int CW = $clog2((2 ** len_bw) + row + col + 1);
   localparam int KW = len_bw + 1;

   localparam logic [CW-1:0] WRD_LAST   = CW'(row);
   localparam logic [CW-1:0] WLOAD_LAST = CW'(row + col - 1);
   localparam logic [CW-1:0] EXEC_TAIL  = CW'(row + col - 1);
   localparam logic [CW-1:0] ROW_C      = CW'(row);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRD,
      S_WLOAD,
      S_XRD,
      S_EXEC,
      S_DRAIN,
`ifdef CORE_INST_GEN_PMEM_READBACK_EN
      S_RDBK,
`endif
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [KW-1:0]     r_q, r_d;
   logic [KW-1:0]     k_q, k_d;
   logic              rd_q, rd_d;
   logic              wr_d;
   logic [10:0]       wr_addr_d;
   logic [10:0]       w_base_q, w_base_d;
   logic [10:0]       x_base_q, x_base_d;
   logic [10:0]       p_base_q, p_base_d;
   logic [len_bw-1:0] len_q, len_d;
   logic              acc_q, acc_d;
   logic [33:0]       inst_q, inst_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [CW-1:0]     len_c;
   logic [KW-1:0]     len_k;

   assign len_c = CW'(len_q);
   assign len_k = KW'(len_q);

   // Next-state, phase counter and drain read/write bookkeeping.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      r_d       = r_q;
      k_d       = k_q;
      rd_d      = 1'b0;
      wr_d      = 1'b0;
      wr_addr_d = p_base_q;
      w_base_d  = w_base_q;
      x_base_d  = x_base_q;
      p_base_d  = p_base_q;
      len_d     = len_q;
      acc_d     = acc_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               w_base_d = w_base;
               x_base_d = x_base;
               p_base_d = p_base;
               len_d    = len;
               acc_d    = acc_i;
               cnt_d    = '0;
               state_d  = S_WRD;
            end
         end
         S_WRD: begin
            if (cnt_q == WRD_LAST) begin
               cnt_d   = '0;
               state_d = S_WLOAD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WLOAD: begin
            if (cnt_q == WLOAD_LAST) begin
               cnt_d   = '0;
               state_d = (len_q == '0) ? S_DONE : S_XRD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_XRD: begin
            if (cnt_q == len_c) begin
               cnt_d   = '0;
               state_d = S_EXEC;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_EXEC: begin
            if (cnt_q == len_c + EXEC_TAIL) begin
               cnt_d   = '0;
               r_d     = '0;
               k_d     = '0;
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (k_q == len_k) begin
               cnt_d = '0;
`ifdef CORE_INST_GEN_PMEM_READBACK_EN
               state_d = S_RDBK;
`else
               state_d = S_DONE;
`endif
            end
         end
`ifdef CORE_INST_GEN_PMEM_READBACK_EN
         S_RDBK: begin
            if (cnt_q == len_c) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // r/k count reads/writes already shown on inst; the write lags its read by one word.
      if (state_d == S_DRAIN) begin
         rd_d      = ofifo_valid && (r_d < len_k);
         wr_d      = rd_q;
         wr_addr_d = p_base_d + 11'(k_d);
         r_d       = r_d + KW'(rd_d);
         k_d       = k_d + KW'(wr_d);
      end
   end

   // Instruction word for the cycle being entered, plus status flags.
   always_comb begin
      inst_d = NOP;
      case (state_d)
         S_WRD: begin
            if (cnt_d < ROW_C) begin
               inst_d[B_CEN_X] = 1'b0;
               inst_d[17:7]    = w_base_d + 11'(cnt_d);
            end
            if (cnt_d != '0) inst_d[B_L0_WR] = 1'b1;
         end
         S_WLOAD: begin
            inst_d[B_L0_RD] = 1'b1;
            inst_d[B_LOAD]  = 1'b1;
         end
         S_XRD: begin
            if (cnt_d < CW'(len_d)) begin
               inst_d[B_CEN_X] = 1'b0;
               inst_d[17:7]    = x_base_d + 11'(cnt_d);
            end
            if (cnt_d != '0) inst_d[B_L0_WR] = 1'b1;
         end
         S_EXEC: begin
            inst_d[B_EXECUTE] = 1'b1;
            inst_d[B_ACC]     = acc_d;
            if (cnt_d < CW'(len_d)) inst_d[B_L0_RD] = 1'b1;
         end
         S_DRAIN: begin
            inst_d[B_OFIFO] = rd_d;
            if (wr_d) begin
               inst_d[B_CEN_P] = 1'b0;
               inst_d[B_WEN_P] = 1'b0;
               inst_d[30:20]   = wr_addr_d;
            end
         end
`ifdef CORE_INST_GEN_PMEM_READBACK_EN
         S_RDBK: begin
            if (cnt_d < CW'(len_d)) begin
               inst_d[B_CEN_P] = 1'b0;
               inst_d[30:20]   = p_base_d + 11'(cnt_d);
            end
         end
`endif
         default: inst_d = NOP;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         r_q      <= '0;
         k_q      <= '0;
         rd_q     <= 1'b0;
         w_base_q <= '0;
         x_base_q <= '0;
         p_base_q <= '0;
         len_q    <= '0;
         acc_q    <= 1'b0;
         inst_q   <= NOP;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         r_q      <= r_d;
         k_q      <= k_d;
         rd_q     <= rd_d;
         w_base_q <= w_base_d;
         x_base_q <= x_base_d;
         p_base_q <= p_base_d;
         len_q    <= len_d;
         acc_q    <= acc_d;
         inst_q   <= inst_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign inst = inst_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
